// File: rtl/hfrv_mem_arbiter_if.sv
// hfrv_mem_arbiter_if: request/acknowledge port shared by the masters of the
// HF-RISC memory arbiter.
//   req    master -> arbiter  request, held with fields stable until ack
//   addr   master -> arbiter  byte address (ADDR_W)
//   wdata  master -> arbiter  write data (DATA_W)
//   wstrb  master -> arbiter  byte strobes (DATA_W/8), all-zero = read
//   ack    arbiter -> master  one-cycle completion pulse
//   rdata  arbiter -> master  read data, valid only while ack is high
interface hfrv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// hfrv_mem_arbiter: round-robin arbiter sharing one synchronous RAM port
// between the CPU core (m0) and the loader/debug master (m1). One access at a
// time is sequenced through IDLE -> ACCESS -> WAIT* -> DONE, with WAIT_STATES
// extra memory cycles per access.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   m0, m1           slave side of the master request/acknowledge ports
//   mem_en           one-cycle memory access strobe (ACCESS state)
//   mem_addr/wdata/wstrb  memory request fields, zero outside ACCESS
//   mem_rdata        memory read data, valid from the cycle after mem_en
//   busy             high in every state except IDLE
// Optional feature, macro HFRV_MEM_ARB_PERF_EN: adds perf_m0_cnt, perf_m1_cnt
// (acks per master) and perf_conflict_cnt (contended arbitration cycles).
module hfrv_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  hfrv_mem_arbiter_if.slave   m0,
  hfrv_mem_arbiter_if.slave   m1,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef HFRV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_m0_cnt,
  output logic [31:0]         perf_m1_cnt,
  output logic [31:0]         perf_conflict_cnt
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_grant;
  logic              w_next_grant;
  logic              r_last_grant;
  logic              w_next_last_grant;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_next_wait_cnt;
  logic              w_other_req;

  // Request of the master that is not currently granted
  assign w_other_req = r_grant ? m0.req : m1.req;

  // State register; last_grant resets to 1 so m0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last_grant;
      r_wait_cnt   <= w_next_wait_cnt;
    end
  end

  // Next-state and arbitration
  always_comb begin
    w_next_state      = r_state;
    w_next_grant      = r_grant;
    w_next_last_grant = r_last_grant;
    w_next_wait_cnt   = r_wait_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (m0.req || m1.req) begin
          w_next_state = ST_ACCESS;
          // Tie goes to whoever was not served last
          if (m0.req && m1.req) w_next_grant = ~r_last_grant;
          else                  w_next_grant = m1.req;
        end
      end
      ST_ACCESS: begin
        w_next_wait_cnt = WAIT_LOAD;
        w_next_state    = (WAIT_LOAD != '0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        w_next_wait_cnt = r_wait_cnt - CNT_W'(1);
        if (r_wait_cnt <= CNT_W'(1)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_last_grant = r_grant;
        // Only the other master may chain straight into a new access;
        // the just-acknowledged master goes back through IDLE
        if (w_other_req) begin
          w_next_grant = ~r_grant;
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the current state and grant
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    m0.ack    = 1'b0;
    m0.rdata  = '0;
    m1.ack    = 1'b0;
    m1.rdata  = '0;
    busy      = (r_state != ST_IDLE);
    unique case (r_state)
      ST_ACCESS: begin
        mem_en = 1'b1;
        if (r_grant) begin
          mem_addr  = m1.addr;
          mem_wdata = m1.wdata;
          mem_wstrb = m1.wstrb;
        end else begin
          mem_addr  = m0.addr;
          mem_wdata = m0.wdata;
          mem_wstrb = m0.wstrb;
        end
      end
      ST_DONE: begin
        // Write acks return zero data
        if (r_grant) begin
          m1.ack   = 1'b1;
          m1.rdata = (m1.wstrb == STRB_W'(0)) ? mem_rdata : '0;
        end else begin
          m0.ack   = 1'b1;
          m0.rdata = (m0.wstrb == STRB_W'(0)) ? mem_rdata : '0;
        end
      end
      default: ;
    endcase
  end

`ifdef HFRV_MEM_ARB_PERF_EN
  logic w_arb_state;

  // Arbitration happens only in IDLE and DONE
  assign w_arb_state = (r_state == ST_IDLE) || (r_state == ST_DONE);

  // Performance counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_m0_cnt       <= '0;
      perf_m1_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if ((r_state == ST_DONE) && !r_grant) perf_m0_cnt <= perf_m0_cnt + 32'd1;
      if ((r_state == ST_DONE) &&  r_grant) perf_m1_cnt <= perf_m1_cnt + 32'd1;
      if (w_arb_state && m0.req && m1.req)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// tb_hfrv_mem_arbiter: directed bench for hfrv_mem_arbiter. DUT "a" runs with
// one wait state against a small synchronous RAM model; DUT "b" runs with zero
// wait states against a constant read-data source.
module tb_hfrv_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hfrv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  hfrv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  hfrv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_m0_if ();
  hfrv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_m1_if ();

  logic              a_mem_en, b_mem_en, a_busy, b_busy;
  logic [ADDR_W-1:0] a_mem_addr, b_mem_addr;
  logic [DATA_W-1:0] a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
  logic [STRB_W-1:0] a_mem_wstrb, b_mem_wstrb;
`ifdef HFRV_MEM_ARB_PERF_EN
  logic [31:0] a_perf_m0, a_perf_m1, a_perf_cf, b_perf_m0, b_perf_m1, b_perf_cf;
`endif

  hfrv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef HFRV_MEM_ARB_PERF_EN
    , .perf_m0_cnt(a_perf_m0), .perf_m1_cnt(a_perf_m1), .perf_conflict_cnt(a_perf_cf)
`endif
  );

  hfrv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .m0(b_m0_if), .m1(b_m1_if),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef HFRV_MEM_ARB_PERF_EN
    , .perf_m0_cnt(b_perf_m0), .perf_m1_cnt(b_perf_m1), .perf_conflict_cnt(b_perf_cf)
`endif
  );

  assign b_mem_rdata = 32'h0000_5A5A;

  // Synchronous RAM model with a backdoor write port for preloading
  logic [31:0] ram [0:255];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_idx] <= bd_data;
    end else if (a_mem_en) begin
      a_mem_rdata <= ram[a_mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (a_mem_wstrb[b]) ram[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single transfer on DUT a; lat = cycles from raising req to ack, -1 on timeout
  task automatic xfer(input bit m, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rd, output int lat);
    int k = 0;
    lat = -1;
    rd  = '0;
    if (!m) begin
      m0_if.req = 1'b1; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.wstrb = wstrb;
    end else begin
      m1_if.req = 1'b1; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.wstrb = wstrb;
    end
    while (lat < 0 && k < 20) begin
      k++;
      @(negedge clk);
      if (!m && m0_if.ack) begin lat = k; rd = m0_if.rdata; end
      if ( m && m1_if.ack) begin lat = k; rd = m1_if.rdata; end
    end
    if (!m) m0_if.req = 1'b0;
    else    m1_if.req = 1'b0;
  endtask

  // Both masters request together; each drops req on its own ack
  task automatic pair();
    bit d0 = 1'b0;
    bit d1 = 1'b0;
    int k  = 0;
    m0_if.req = 1'b1; m0_if.addr = 32'h100; m0_if.wstrb = 4'h0;
    m1_if.req = 1'b1; m1_if.addr = 32'h040; m1_if.wstrb = 4'h0;
    while (!(d0 && d1) && k < 30) begin
      k++;
      @(negedge clk);
      if (m0_if.ack) begin d0 = 1'b1; m0_if.req = 1'b0; end
      if (m1_if.ack) begin d1 = 1'b1; m1_if.req = 1'b0; end
    end
    check("pair_done", 32'({d0, d1}), 32'h3);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    reset = 1'b1;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    b_m0_if.req = 1'b0; b_m0_if.addr = '0; b_m0_if.wdata = '0; b_m0_if.wstrb = '0;
    b_m1_if.req = 1'b0; b_m1_if.addr = '0; b_m1_if.wdata = '0; b_m1_if.wstrb = '0;

    // Preload 0x100 with 0xDEADBEEF during reset
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 8'd64; bd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bd_we = 1'b0;
    check("rst_busy",   32'(a_busy), 32'h0);
    check("rst_mem_en", 32'(a_mem_en), 32'h0);
    check("rst_addr",   a_mem_addr, 32'h0);
    check("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    check("rst_m1_ack", 32'(m1_if.ack), 32'h0);
    check("rst_b_busy", 32'(b_busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // m0 read of 0x100: mem_en at N+1, ack at N+3
    m0_if.req = 1'b1; m0_if.addr = 32'h100; m0_if.wstrb = 4'h0;
    @(negedge clk);
    check("rd_en",    32'(a_mem_en), 32'h1);
    check("rd_addr",  a_mem_addr, 32'h100);
    check("rd_strb",  32'(a_mem_wstrb), 32'h0);
    check("rd_busy1", 32'(a_busy), 32'h1);
    @(negedge clk);
    check("rd_en_w",  32'(a_mem_en), 32'h0);
    check("rd_busy2", 32'(a_busy), 32'h1);
    check("rd_ack_w", 32'(m0_if.ack), 32'h0);
    @(negedge clk);
    check("rd_ack",   32'(m0_if.ack), 32'h1);
    check("rd_data",  m0_if.rdata, 32'hDEAD_BEEF);
    check("rd_m1ack", 32'(m1_if.ack), 32'h0);
    check("rd_busy3", 32'(a_busy), 32'h1);
    m0_if.req = 1'b0;
    @(negedge clk);
    check("rd_idle",  32'(a_busy), 32'h0);

    // m1 write 0x13 to 0x40, then m0 reads it back
    m1_if.req = 1'b1; m1_if.addr = 32'h40; m1_if.wdata = 32'h13; m1_if.wstrb = 4'hF;
    @(negedge clk);
    check("wr_en",    32'(a_mem_en), 32'h1);
    check("wr_addr",  a_mem_addr, 32'h40);
    check("wr_wdata", a_mem_wdata, 32'h13);
    check("wr_strb",  32'(a_mem_wstrb), 32'hF);
    repeat (2) @(negedge clk);
    check("wr_ack",   32'(m1_if.ack), 32'h1);
    check("wr_rdata", m1_if.rdata, 32'h0);
    m1_if.req = 1'b0;
    @(negedge clk);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    check("rb_lat",  32'(lat), 32'd3);
    check("rb_data", rd, 32'h13);
    repeat (2) @(negedge clk);

    // Simultaneous requests out of reset: grants 0,1,0,1
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 32'h100; m0_if.wstrb = 4'h0;
    m1_if.req = 1'b1; m1_if.addr = 32'h040; m1_if.wstrb = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("rr_en_%0d", k),  32'(a_mem_en),  32'(k % 3 == 1));
      check($sformatf("rr_a0_%0d", k),  32'(m0_if.ack), 32'(k == 3 || k == 9));
      check($sformatf("rr_a1_%0d", k),  32'(m1_if.ack), 32'(k == 6 || k == 12));
      if (k % 3 == 1)
        check($sformatf("rr_addr_%0d", k), a_mem_addr, (k == 1 || k == 7) ? 32'h100 : 32'h40);
      if (k == 3 || k == 9)  check($sformatf("rr_d0_%0d", k), m0_if.rdata, 32'hDEAD_BEEF);
      if (k == 6 || k == 12) check($sformatf("rr_d1_%0d", k), m1_if.rdata, 32'h13);
      if (k == 12) begin m0_if.req = 1'b0; m1_if.req = 1'b0; end
    end
    repeat (2) @(negedge clk);
    check("rr_idle", 32'(a_busy), 32'h0);

    // Zero wait states, m0 requesting continuously: ack and mem_en every 3 cycles
    b_m0_if.req = 1'b1; b_m0_if.addr = 32'h200; b_m0_if.wstrb = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("ws0_en_%0d", k),  32'(b_mem_en),    32'(k % 3 == 1));
      check($sformatf("ws0_ack_%0d", k), 32'(b_m0_if.ack), 32'(k % 3 == 2));
      if (k % 3 == 2) check($sformatf("ws0_d_%0d", k), b_m0_if.rdata, 32'h5A5A);
      if (k == 9) b_m0_if.req = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("ws0_idle", 32'(b_busy), 32'h0);

    // Reset during the WAIT cycle of an m1 read
    m1_if.req = 1'b1; m1_if.addr = 32'h40; m1_if.wstrb = 4'h0;
    @(negedge clk);
    check("rw_en", 32'(a_mem_en), 32'h1);
    @(negedge clk);
    check("rw_busy", 32'(a_busy), 32'h1);
    reset = 1'b1;
    #1;
    check("rw_busy_rst", 32'(a_busy), 32'h0);
    check("rw_en_rst",   32'(a_mem_en), 32'h0);
    check("rw_ack_rst",  32'(m1_if.ack), 32'h0);
    @(negedge clk);
    check("rw_noack", 32'(m1_if.ack), 32'h0);
    check("rw_rdata", m1_if.rdata, 32'h0);
    m1_if.req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    xfer(1'b1, 32'h40, 32'h0, 4'h0, rd, lat);
    check("rw_new_lat",  32'(lat), 32'd3);
    check("rw_new_data", rd, 32'h13);
    repeat (2) @(negedge clk);

`ifdef HFRV_MEM_ARB_PERF_EN
    // 5 m0 and 3 m1 transfers, two of them contended pairs
    do_reset();
    check("perf_m0_rst", a_perf_m0, 32'd0);
    check("perf_m1_rst", a_perf_m1, 32'd0);
    check("perf_cf_rst", a_perf_cf, 32'd0);
    pair();
    pair();
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
      check($sformatf("perf_m0_lat_%0d", i), 32'(lat), 32'd3);
    end
    xfer(1'b1, 32'h40, 32'h0, 4'h0, rd, lat);
    check("perf_m1_lat", 32'(lat), 32'd3);
    repeat (2) @(negedge clk);
    check("perf_m0", a_perf_m0, 32'd5);
    check("perf_m1", a_perf_m1, 32'd3);
    check("perf_cf_ge2", 32'(a_perf_cf >= 32'd2), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hfrv_mem_arbiter.md
# hfrv_mem_arbiter

Two-master arbiter that shares the single synchronous RAM port of the HF-RISC verification top between the CPU core (master 0) and the testbench program loader/debug master (master 1). Each master uses a request/acknowledge handshake; the arbiter sequences one memory transaction at a time through a small FSM, inserts a configurable number of wait states and returns read data with the acknowledge. Round-robin arbitration prevents the loader from starving the core, and vice versa.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.
- `WAIT_STATES`, 1, extra memory cycles per access, legal range 0..7.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mN_req`  in  1  master N request (N = 0, 1); held high with fields stable until `mN_ack`.
- `mN_addr`  in  ADDR_W  master N address.
- `mN_wdata`  in  DATA_W  master N write data.
- `mN_wstrb`  in  DATA_W/8  byte strobes; all-zero means read.
- `mN_ack`  out  1  one-cycle completion pulse to master N.
- `mN_rdata`  out  DATA_W  read data, valid only while `mN_ack` is high.
- `mem_en`  out  1  one-cycle memory access strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_wstrb`  out  DATA_W/8  memory byte strobes; zero = read.
- `mem_rdata`  in  DATA_W  memory read data; valid from the cycle after `mem_en` until the next `mem_en`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE. Registers: `grant` (1 bit), `last_grant` (1 bit), wait counter (3 bits).
- IDLE: no request keeps IDLE. One request grants that master. Two requests grant `!last_grant`. Next state is ACCESS.
- ACCESS: `mem_en`=1. `mem_addr`/`mem_wdata`/`mem_wstrb` come from the granted master. Load the counter with `WAIT_STATES`. Next state is WAIT if `WAIT_STATES`>0, else DONE.
- WAIT: decrement the counter. When the counter reaches 1, the next state is DONE.
- DONE: `mN_ack`=1 for the granted master. `mN_rdata`=`mem_rdata` for reads and 0 for writes. `last_grant` is set to `grant`. If the other master's `req` is high, grant it and go directly to ACCESS; otherwise go to IDLE. The acknowledged master's `req` is ignored in DONE.
- `mem_*` outputs are 0 outside ACCESS. The un-granted master's `ack`/`rdata` are always 0.
- Masters must drop `req` or present a new request in the cycle after `ack`. Changing fields while `req` is high and not yet acknowledged is illegal; behaviour is undefined.

## Timing
- Reset values: every output 0; state IDLE; `grant`=0; `last_grant`=1, so master 0 wins the first tie; counter 0.
- Latency: a request sampled in IDLE at cycle N gives `mem_en` at N+1 and `ack` at N+2+`WAIT_STATES`.
- Back-to-back alternating transfers: period 2+`WAIT_STATES` cycles. Same-master repeat: period 3+`WAIT_STATES` cycles, because it passes through IDLE.
- Requests arriving during ACCESS/WAIT are held pending. They are arbitrated in DONE (other master only) or in IDLE.
- Simultaneous first requests out of reset: master 0 is granted, then master 1.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0 and no `ack`. A write whose `mem_en` already pulsed stays committed in memory.

## Configuration
- `HFRV_MEM_ARB_PERF_EN` defined:
  - adds outputs `perf_m0_cnt` and `perf_m1_cnt` (32 bits each), incremented on each `ack` to that master;
  - adds `perf_conflict_cnt` (32 bits), incremented in each cycle where both `req` are high and the FSM is in IDLE or DONE;
  - all three counters wrap at 2^32 and reset to 0.
- `HFRV_MEM_ARB_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- `WAIT_STATES`=1. m0 reads 0x100, memory returns 0xDEADBEEF → `mem_en` at N+1, `m0_ack` with `m0_rdata`=0xDEADBEEF at N+3, `busy` high N+1..N+3.
- m1 writes 0x0000_0013 to 0x40 with `wstrb`=4'hF, then m0 reads 0x40 → `m0_rdata`=0x0000_0013, `m1_rdata`=0 on its write `ack`.
- Both masters request in the same cycle out of reset → m0 acknowledged first. m1's `mem_en` comes in the cycle after m0's `ack`. Both keep requesting → grants alternate 0,1,0,1.
- `WAIT_STATES`=0, m0 requests continuously → `ack` every 3 cycles and `mem_en` every 3 cycles.
- `reset` pulsed in the WAIT cycle of an m1 read → no `m1_ack`, all outputs 0 next edge. A new m1 request after reset completes normally.
- With `HFRV_MEM_ARB_PERF_EN`: 5 m0 and 3 m1 transfers, 2 of them contended → `perf_m0_cnt`=5, `perf_m1_cnt`=3, `perf_conflict_cnt` ≥2.
